// File: rtl/main_control_fsm.sv
// Multi-cycle main control unit for the 16-bit RISC datapath: fetch/decode/exec/mem/wb
// sequencing, ALU class codes, datapath strobes, memory handshake and halt reporting.
module main_control_fsm #(
    parameter int WAIT_MAX = 15,
    parameter int RET_W    = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       OPCODE,
    input  logic             ZERO,
    input  logic             MEM_RDY,
    output logic [1:0]       ALU_OP,
    output logic             ALU_SRC,
    output logic             PC_WE,
    output logic [1:0]       PC_SRC,
    output logic             IR_WE,
    output logic             REG_WE,
    output logic             MEM_TO_REG,
    output logic             MEM_RD,
    output logic             MEM_WR,
    output logic             ILLEGAL,
    output logic             BUS_ERR,
    output logic [2:0]       STATE,
    output logic [RET_W-1:0] RETIRED
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_HALT   = 3'b101
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_BEQ   = 4'hA;
    localparam logic [3:0] OP_BNE   = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);
    localparam logic [RET_W-1:0] RET_ONE = {{(RET_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [3:0] op_q;
    logic [7:0] wait_cnt;
    logic       timeout;
    logic       op_ls;
    logic       op_rtype;

    // The cycle that would make the count reach WAIT_MAX trips the timeout, unless ready wins.
    assign timeout  = !MEM_RDY && (wait_cnt == WAIT_LAST);
    assign op_ls    = (op_q == OP_LOAD) || (op_q == OP_STORE);
    assign op_rtype = (op_q >= 4'h2) && (op_q <= 4'h9);
    assign STATE    = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_FETCH;
            op_q     <= 4'h0;
            wait_cnt <= 8'd0;
            ILLEGAL  <= 1'b0;
            BUS_ERR  <= 1'b0;
            RETIRED  <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (MEM_RDY) begin
                        wait_cnt <= 8'd0;
                        state    <= S_DECODE;
                    end else if (timeout) begin
                        wait_cnt <= 8'd0;
                        BUS_ERR  <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    op_q <= OPCODE;
                    if (OPCODE >= 4'hD) begin
                        ILLEGAL <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_ls) begin
                        state <= S_MEM;
                    end else if (op_rtype) begin
                        state <= S_WB;
                    end else begin
                        RETIRED <= RETIRED + RET_ONE;
                        state   <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (MEM_RDY) begin
                        wait_cnt <= 8'd0;
                        if (op_q == OP_LOAD) begin
                            state <= S_WB;
                        end else begin
                            RETIRED <= RETIRED + RET_ONE;
                            state   <= S_FETCH;
                        end
                    end else if (timeout) begin
                        wait_cnt <= 8'd0;
                        BUS_ERR  <= 1'b1;
                        state    <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    RETIRED <= RETIRED + RET_ONE;
                    state   <= S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: begin
                    ILLEGAL <= 1'b1;
                    state   <= S_HALT;
                end
            endcase
        end
    end

    // Strobes are gated by RST_N so nothing is held while reset is asserted.
    always_comb begin
        ALU_OP     = 2'b00;
        ALU_SRC    = 1'b0;
        PC_WE      = 1'b0;
        PC_SRC     = 2'b00;
        IR_WE      = 1'b0;
        REG_WE     = 1'b0;
        MEM_TO_REG = 1'b0;
        MEM_RD     = 1'b0;
        MEM_WR     = 1'b0;
        if (RST_N) begin
            case (state)
                S_FETCH: begin
                    MEM_RD = 1'b1;
                    IR_WE  = MEM_RDY;
                    PC_WE  = MEM_RDY;
                end
                S_EXEC: begin
                    if (op_ls) begin
                        ALU_OP  = 2'b10;
                        ALU_SRC = 1'b1;
                    end else if (op_q == OP_BEQ || op_q == OP_BNE) begin
                        ALU_OP = 2'b01;
                        PC_SRC = 2'b01;
                        PC_WE  = (op_q == OP_BEQ) ? ZERO : !ZERO;
                    end else if (op_q == OP_JMP) begin
                        PC_SRC = 2'b10;
                        PC_WE  = 1'b1;
                    end
                end
                S_MEM: begin
                    ALU_OP  = 2'b10;
                    ALU_SRC = 1'b1;
                    MEM_RD  = (op_q == OP_LOAD);
                    MEM_WR  = (op_q == OP_STORE);
                end
                S_WB: begin
                    REG_WE     = 1'b1;
                    MEM_TO_REG = (op_q == OP_LOAD);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: directed scenarios plus a randomized
// instruction stream checked against an instruction-level model.
module tb_main_control_fsm;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [3:0]  OPCODE;
    logic        ZERO;
    logic        MEM_RDY;
    logic [1:0]  ALU_OP;
    logic        ALU_SRC;
    logic        PC_WE;
    logic [1:0]  PC_SRC;
    logic        IR_WE;
    logic        REG_WE;
    logic        MEM_TO_REG;
    logic        MEM_RD;
    logic        MEM_WR;
    logic        ILLEGAL;
    logic        BUS_ERR;
    logic [2:0]  STATE;
    logic [15:0] RETIRED;

    main_control_fsm #(.WAIT_MAX(15), .RET_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .OPCODE(OPCODE), .ZERO(ZERO), .MEM_RDY(MEM_RDY),
        .ALU_OP(ALU_OP), .ALU_SRC(ALU_SRC), .PC_WE(PC_WE), .PC_SRC(PC_SRC),
        .IR_WE(IR_WE), .REG_WE(REG_WE), .MEM_TO_REG(MEM_TO_REG), .MEM_RD(MEM_RD),
        .MEM_WR(MEM_WR), .ILLEGAL(ILLEGAL), .BUS_ERR(BUS_ERR), .STATE(STATE),
        .RETIRED(RETIRED)
    );

    always #5 CLK = ~CLK;

    // {ALU_OP, ALU_SRC, PC_WE, PC_SRC, IR_WE, REG_WE, MEM_TO_REG, MEM_RD, MEM_WR}
    wire [10:0] obs = {ALU_OP, ALU_SRC, PC_WE, PC_SRC, IR_WE, REG_WE, MEM_TO_REG, MEM_RD, MEM_WR};

    localparam logic [10:0] NONE      = 11'b00_0_0_00_0_0_0_0_0;
    localparam logic [10:0] FETCH_RDY = 11'b00_0_1_00_1_0_0_1_0;
    localparam logic [10:0] FETCH_WT  = 11'b00_0_0_00_0_0_0_1_0;
    localparam logic [10:0] EX_LS     = 11'b10_1_0_00_0_0_0_0_0;
    localparam logic [10:0] MEM_LD    = 11'b10_1_0_00_0_0_0_1_0;
    localparam logic [10:0] MEM_ST    = 11'b10_1_0_00_0_0_0_0_1;
    localparam logic [10:0] WB_LD     = 11'b00_0_0_00_0_1_1_0_0;
    localparam logic [10:0] WB_R      = 11'b00_0_0_00_0_1_0_0_0;
    localparam logic [10:0] BR_TAKEN  = 11'b01_0_1_01_0_0_0_0_0;
    localparam logic [10:0] BR_NOT    = 11'b01_0_0_01_0_0_0_0_0;
    localparam logic [10:0] EX_JMP    = 11'b00_0_1_10_0_0_0_0_0;

    typedef struct packed {
        logic [3:0]  op;
        logic        z;
        logic        rdy;
        logic [2:0]  st;
        logic [10:0] ob;
    } row_t;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_ret;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic rdy, input logic z, input logic [3:0] op);
        @(negedge CLK);
        MEM_RDY = rdy;
        ZERO    = z;
        OPCODE  = op;
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; MEM_RDY = 1'b1; OPCODE = 4'h2;
        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if (STATE !== 3'b000 || obs !== NONE || ILLEGAL !== 1'b0 || BUS_ERR !== 1'b0 || RETIRED !== 16'd0) begin
            failures++;
            $display("FAIL reset_state state=%b strobes=%b ill=%b berr=%b ret=%0d required 000/0/0/0/0",
                     STATE, obs, ILLEGAL, BUS_ERR, RETIRED);
        end
        MEM_RDY = 1'b0;
        RST_N   = 1'b1;
        exp_ret = 16'd0;
    endtask

    task automatic test_add();
        row_t rows [4];
        rows = '{'{4'h2, 1'b0, 1'b1, 3'd0, FETCH_RDY}, '{4'h2, 1'b0, 1'b1, 3'd1, NONE},
                 '{4'h2, 1'b0, 1'b1, 3'd2, NONE},      '{4'h2, 1'b0, 1'b1, 3'd4, WB_R}};
        for (int i = 0; i < 4; i++) begin
            drive(rows[i].rdy, rows[i].z, rows[i].op);
            checks++;
            if (STATE !== rows[i].st || obs !== rows[i].ob) begin
                failures++;
                $display("FAIL add_seq cyc=%0d state=%b strobes=%b required %b/%b", i, STATE, obs, rows[i].st, rows[i].ob);
            end
        end
        exp_ret++;
        drive(1'b0, 1'b0, 4'h2);
        checks++;
        if (STATE !== 3'b000 || RETIRED !== exp_ret) begin
            failures++;
            $display("FAIL add_retire state=%b ret=%0d required 000/%0d", STATE, RETIRED, exp_ret);
        end
    endtask

    task automatic test_load();
        row_t rows [8];
        rows = '{'{4'h0, 1'b0, 1'b1, 3'd0, FETCH_RDY}, '{4'h0, 1'b0, 1'b1, 3'd1, NONE},
                 '{4'h0, 1'b0, 1'b1, 3'd2, EX_LS},     '{4'h0, 1'b0, 1'b0, 3'd3, MEM_LD},
                 '{4'h0, 1'b0, 1'b0, 3'd3, MEM_LD},    '{4'h0, 1'b0, 1'b0, 3'd3, MEM_LD},
                 '{4'h0, 1'b0, 1'b1, 3'd3, MEM_LD},    '{4'h0, 1'b0, 1'b1, 3'd4, WB_LD}};
        for (int i = 0; i < 8; i++) begin
            drive(rows[i].rdy, rows[i].z, rows[i].op);
            checks++;
            if (STATE !== rows[i].st || obs !== rows[i].ob) begin
                failures++;
                $display("FAIL load_seq cyc=%0d state=%b strobes=%b required %b/%b", i, STATE, obs, rows[i].st, rows[i].ob);
            end
        end
        exp_ret++;
        drive(1'b0, 1'b0, 4'h0);
        checks++;
        if (STATE !== 3'b000 || RETIRED !== exp_ret) begin
            failures++;
            $display("FAIL load_retire state=%b ret=%0d required 000/%0d", STATE, RETIRED, exp_ret);
        end
    endtask

    task automatic test_branch();
        row_t rows [6];
        rows = '{'{4'hA, 1'b1, 1'b1, 3'd0, FETCH_RDY}, '{4'hA, 1'b1, 1'b1, 3'd1, NONE},
                 '{4'hA, 1'b1, 1'b1, 3'd2, BR_TAKEN},  '{4'hB, 1'b1, 1'b1, 3'd0, FETCH_RDY},
                 '{4'hB, 1'b1, 1'b1, 3'd1, NONE},      '{4'hB, 1'b1, 1'b1, 3'd2, BR_NOT}};
        for (int i = 0; i < 6; i++) begin
            drive(rows[i].rdy, rows[i].z, rows[i].op);
            checks++;
            if (STATE !== rows[i].st || obs !== rows[i].ob) begin
                failures++;
                $display("FAIL branch_seq cyc=%0d state=%b strobes=%b required %b/%b", i, STATE, obs, rows[i].st, rows[i].ob);
            end
        end
        exp_ret += 16'd2;
        drive(1'b0, 1'b0, 4'h0);
        checks++;
        if (STATE !== 3'b000 || RETIRED !== exp_ret) begin
            failures++;
            $display("FAIL branch_retire state=%b ret=%0d required 000/%0d", STATE, RETIRED, exp_ret);
        end
    endtask

    // Instruction-level model: each opcode class implies a fixed phase list and strobe set.
    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  op;
            logic        z;
            logic        rdy;
            int          fw;
            int          mw;
            logic [10:0] exp;
            op = 4'($urandom_range(0, 12));
            z  = 1'($urandom_range(0, 1));
            fw = $urandom_range(0, 3);
            mw = $urandom_range(0, 3);
            for (int w = 0; w <= fw; w++) begin
                rdy = (w == fw);
                drive(rdy, 1'($urandom), 4'($urandom));
                exp = rdy ? FETCH_RDY : FETCH_WT;
                checks++;
                if (STATE !== 3'b000 || obs !== exp || (w == 0 && RETIRED !== exp_ret)) begin
                    failures++;
                    $display("FAIL rand_fetch n=%0d state=%b strobes=%b ret=%0d required 000/%b/%0d",
                             n, STATE, obs, RETIRED, exp, exp_ret);
                end
            end
            drive(1'($urandom), z, op);
            checks++;
            if (STATE !== 3'b001 || obs !== NONE) begin
                failures++;
                $display("FAIL rand_decode n=%0d op=%h state=%b strobes=%b required 001/%b", n, op, STATE, obs, NONE);
            end
            drive(1'($urandom), z, op);
            if (op <= 4'h1)        exp = EX_LS;
            else if (op == 4'hA)   exp = z ? BR_TAKEN : BR_NOT;
            else if (op == 4'hB)   exp = z ? BR_NOT : BR_TAKEN;
            else if (op == 4'hC)   exp = EX_JMP;
            else                   exp = NONE;
            checks++;
            if (STATE !== 3'b010 || obs !== exp) begin
                failures++;
                $display("FAIL rand_exec n=%0d op=%h z=%b state=%b strobes=%b required 010/%b", n, op, z, STATE, obs, exp);
            end
            if (op <= 4'h1) begin
                for (int w = 0; w <= mw; w++) begin
                    drive(w == mw, z, op);
                    exp = (op == 4'h0) ? MEM_LD : MEM_ST;
                    checks++;
                    if (STATE !== 3'b011 || obs !== exp) begin
                        failures++;
                        $display("FAIL rand_mem n=%0d op=%h state=%b strobes=%b required 011/%b", n, op, STATE, obs, exp);
                    end
                end
            end
            if (op == 4'h0 || (op >= 4'h2 && op <= 4'h9)) begin
                drive(1'($urandom), z, op);
                exp = (op == 4'h0) ? WB_LD : WB_R;
                checks++;
                if (STATE !== 3'b100 || obs !== exp) begin
                    failures++;
                    $display("FAIL rand_wb n=%0d op=%h state=%b strobes=%b required 100/%b", n, op, STATE, obs, exp);
                end
            end
            exp_ret++;
        end
        drive(1'b0, 1'b0, 4'h0);
        checks++;
        if (STATE !== 3'b000 || RETIRED !== exp_ret || ILLEGAL !== 1'b0 || BUS_ERR !== 1'b0) begin
            failures++;
            $display("FAIL rand_end state=%b ret=%0d ill=%b berr=%b required 000/%0d/0/0",
                     STATE, RETIRED, ILLEGAL, BUS_ERR, exp_ret);
        end
    endtask

    task automatic test_reset_mid_store();
        drive(1'b1, 1'b0, 4'h1);
        drive(1'b1, 1'b0, 4'h1);
        drive(1'b0, 1'b0, 4'h1);
        drive(1'b0, 1'b0, 4'h1);
        checks++;
        if (STATE !== 3'b011 || obs !== MEM_ST) begin
            failures++;
            $display("FAIL store_mem state=%b strobes=%b required 011/%b", STATE, obs, MEM_ST);
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if (MEM_WR !== 1'b0 || STATE !== 3'b000 || RETIRED !== 16'd0 || obs !== NONE) begin
            failures++;
            $display("FAIL store_abort memwr=%b state=%b ret=%0d strobes=%b required 0/000/0/%b",
                     MEM_WR, STATE, RETIRED, obs, NONE);
        end
        exp_ret = 16'd0;
        @(negedge CLK);
        MEM_RDY = 1'b0;
        RST_N   = 1'b1;
        #1;
        checks++;
        if (STATE !== 3'b000 || obs !== FETCH_WT) begin
            failures++;
            $display("FAIL store_restart state=%b strobes=%b required 000/%b", STATE, obs, FETCH_WT);
        end
    endtask

    task automatic test_illegal();
        drive(1'b1, 1'b0, 4'hE);
        drive(1'b1, 1'b0, 4'hE);
        checks++;
        if (STATE !== 3'b001 || ILLEGAL !== 1'b0) begin
            failures++;
            $display("FAIL illegal_decode state=%b ill=%b required 001/0", STATE, ILLEGAL);
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom), 1'($urandom), 4'hE);
            checks++;
            if (STATE !== 3'b101 || ILLEGAL !== 1'b1 || obs !== NONE || RETIRED !== exp_ret) begin
                failures++;
                $display("FAIL illegal_halt cyc=%0d state=%b ill=%b strobes=%b ret=%0d required 101/1/0/%0d",
                         i, STATE, ILLEGAL, obs, RETIRED, exp_ret);
            end
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if (ILLEGAL !== 1'b0 || STATE !== 3'b000) begin
            failures++;
            $display("FAIL illegal_clear ill=%b state=%b required 0/000", ILLEGAL, STATE);
        end
        exp_ret = 16'd0;
    endtask

    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            RST_N = 1'b0;
            @(negedge CLK);
            for (int w = 0; w < 15; w++) begin
                if (w == 0) begin
                    MEM_RDY = 1'b0;
                    RST_N   = 1'b1;
                    #1;
                end else begin
                    drive((pass == 1) && (w == 14), 1'b0, 4'h2);
                end
                checks++;
                if (STATE !== 3'b000 || MEM_RD !== 1'b1 || BUS_ERR !== 1'b0 || IR_WE !== ((pass == 1) && (w == 14))) begin
                    failures++;
                    $display("FAIL timeout_wait pass=%0d w=%0d state=%b rd=%b ir=%b berr=%b", pass, w, STATE, MEM_RD, IR_WE, BUS_ERR);
                end
            end
            drive(1'b1, 1'b0, 4'h2);
            checks++;
            if (pass == 0 && (STATE !== 3'b101 || BUS_ERR !== 1'b1 || obs !== NONE)) begin
                failures++;
                $display("FAIL timeout_halt state=%b berr=%b strobes=%b required 101/1/0", STATE, BUS_ERR, obs);
            end else if (pass == 1 && (STATE !== 3'b001 || BUS_ERR !== 1'b0)) begin
                failures++;
                $display("FAIL timeout_ready_wins state=%b berr=%b required 001/0", STATE, BUS_ERR);
            end
        end
    endtask

    initial begin
        OPCODE = 4'h0; ZERO = 1'b0; MEM_RDY = 1'b0; RST_N = 1'b0; exp_ret = 16'd0;
        test_reset();
        test_add();
        test_load();
        test_branch();
        test_random();
        test_reset_mid_store();
        test_illegal();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/main_control_fsm.md
Name: main_control_fsm

Overview:
- Multi-cycle main control unit for the 16-b RISC datapath. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Produces the 2-b ALU_OP class code that the ALU control decoder combines with OPCODE:
  - 00 = R-type, function taken from OPCODE
  - 10 = load/store address add
  - 01 = branch compare subtract
- Also drives the PC, IR, register-file and memory strobes, handshakes with the memory interface, and reports illegal-opcode and bus-timeout halts.

Parameters:
WAIT_MAX, 15, memory wait cycles tolerated per request before bus-error halt (1..255)
RET_W, 16, width of retired-instruction counter

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
OPCODE  input  4  IR[15:12], valid from DECODE onward
ZERO  input  1  ALU zero flag, valid in EXEC
MEM_RDY  input  1  memory acknowledges current MEM_RD/MEM_WR this cycle
ALU_OP  output  2  class code to ALU control
ALU_SRC  output  1  1 = ALU B operand from sign-extended offset
PC_WE  output  1  PC load strobe
PC_SRC  output  2  00 = PC+2, 01 = branch target, 10 = jump target
IR_WE  output  1  instruction register load strobe
REG_WE  output  1  register file write strobe
MEM_TO_REG  output  1  1 = writeback data from memory
MEM_RD  output  1  memory read request
MEM_WR  output  1  memory write request
ILLEGAL  output  1  sticky, undefined opcode decoded
BUS_ERR  output  1  sticky, memory wait exceeded WAIT_MAX
STATE  output  3  current state encoding, for debug
RETIRED  output  RET_W  count of completed instructions

Behaviour:
- Opcode map:
  - 0000 LOAD, 0001 STORE
  - 0010 ADD, 0011 SUB, 0100 NOT, 0101 LSL, 0110 LSR, 0111 AND, 1000 OR, 1001 SLT
  - 1010 BEQ, 1011 BNE, 1100 JMP
  - 1101..1111 illegal
- States: FETCH=000, DECODE=001, EXEC=010, MEM=011, WB=100, HALT=101. Encodings 110/111 go to HALT with ILLEGAL=1.
- Reset (RST_N low, async):
  - STATE=FETCH; all strobes 0; ALU_OP=00, ALU_SRC=0, PC_SRC=00, MEM_TO_REG=0.
  - ILLEGAL=0, BUS_ERR=0, RETIRED=0, wait counter=0.
  - Reset asserted mid-operation aborts immediately; no strobe is held into reset.
- All outputs except RETIRED/ILLEGAL/BUS_ERR/STATE are combinational from STATE, latched opcode, ZERO and MEM_RDY (Moore-plus-ready). All others are registered.
- FETCH:
  - MEM_RD=1.
  - While MEM_RDY=0: stay, increment wait counter.
  - On MEM_RDY=1: IR_WE=1, PC_WE=1, PC_SRC=00, clear counter, go to DECODE.
- DECODE:
  - One cycle; OPCODE captured into internal register.
  - Illegal opcode -> HALT, ILLEGAL set; otherwise -> EXEC.
- EXEC:
  - R-type: ALU_OP=00, ALU_SRC=0 -> WB.
  - LOAD/STORE: ALU_OP=10, ALU_SRC=1 -> MEM.
  - BEQ/BNE: ALU_OP=01, ALU_SRC=0, PC_SRC=01. PC_WE=ZERO for BEQ, PC_WE=~ZERO for BNE. -> FETCH, RETIRED++.
  - JMP: PC_SRC=10, PC_WE=1 -> FETCH, RETIRED++.
- MEM:
  - ALU_OP=10 and ALU_SRC=1 are held so the address stays stable.
  - LOAD asserts MEM_RD; STORE asserts MEM_WR. Exactly one is high.
  - Request is held until MEM_RDY=1, with the same counter rules as FETCH.
  - LOAD -> WB; STORE -> FETCH, RETIRED++.
- WB:
  - REG_WE=1; MEM_TO_REG=1 only for LOAD.
  - -> FETCH, RETIRED++.
- Timeout: the wait counter counts consecutive cycles with a request pending and MEM_RDY=0.
  - When the counter reaches WAIT_MAX, next state is HALT and BUS_ERR is set; the request drops.
  - MEM_RDY=1 in the same cycle the counter hits WAIT_MAX is treated as a success. Ready wins.
- HALT:
  - All strobes 0. STATE=101.
  - Exit only via reset. MEM_RDY is ignored.
- Latency: MEM_RDY tied high gives R-type 4 cycles, LOAD 5, STORE 4, branch/JMP 3.
- RETIRED wraps from 2^RET_W-1 to 0. It never increments in HALT.
- MEM_RD and MEM_WR are never asserted together. REG_WE and PC_WE are never asserted in the same cycle.

Test Plan:
- Reset then ADD (0010), MEM_RDY=1: STATE sequence 000,001,010,100,000; ALU_OP=00 in EXEC; REG_WE=1 in WB with MEM_TO_REG=0; RETIRED=1.
- LOAD (0000), MEM_RDY low 3 cycles in MEM: ALU_OP=10, ALU_SRC=1 in EXEC and MEM; MEM_RD held 4 cycles; WB has MEM_TO_REG=1; total 8 cycles.
- BEQ with ZERO=1 -> PC_WE=1, PC_SRC=01, ALU_OP=01. BNE with ZERO=1 -> PC_WE=0. Both return to FETCH; RETIRED +2.
- OPCODE=1110: ILLEGAL=1 and STATE=101 after DECODE; all strobes remain 0 for 20 cycles; RST_N low clears ILLEGAL and STATE=000.
- WAIT_MAX=15, MEM_RDY held 0 in FETCH: BUS_ERR=1 and HALT after 15 wait cycles. Repeat with MEM_RDY=1 on the 15th cycle: normal DECODE, BUS_ERR=0.
- RST_N pulsed low during MEM of STORE: MEM_WR drops asynchronously; RETIRED=0; restart in FETCH.
